// File: rtl/usb_mem_loader_ctrl_if.sv
// USB register port plus OBI write-master signals of the memory loader, bundled for one port connection.
// Latency: none, wires only.
// Backpressure: carried by bus_gnt_i/bus_rvalid_i on the bus side; the register side has none.
interface usb_mem_loader_ctrl_if;
    logic        reg_wr_i;
    logic [3:0]  reg_addr_i;
    logic [7:0]  reg_wdata_i;
    logic [7:0]  reg_rdata_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic        fetch_enable_o;
    logic        busy_o;
    logic        err_o;

    // loader side: consumes register writes and bus responses, drives the bus request
    modport master (
        input  reg_wr_i, reg_addr_i, reg_wdata_i, bus_gnt_i, bus_rvalid_i,
        output reg_rdata_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        output fetch_enable_o, busy_o, err_o
    );

    // host/memory side: drives register writes and bus responses
    modport slave (
        output reg_wr_i, reg_addr_i, reg_wdata_i, bus_gnt_i, bus_rvalid_i,
        input  reg_rdata_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        input  fetch_enable_o, busy_o, err_o
    );
endinterface

// File: rtl/usb_mem_loader_ctrl.sv
// Packs byte-wide USB register writes into 32-bit OBI word writes at an auto-incrementing pointer.
// Latency: bus_req_o rises the cycle after the DATA3 write; one outstanding transaction, no back-to-back.
// Backpressure: FIFO_D-word FIFO absorbs grant stalls; a push into a full FIFO is dropped and flagged.
module usb_mem_loader_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int FIFO_D  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    usb_mem_loader_ctrl_if.master io
);
    localparam int AW = $clog2(FIFO_D);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_D);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   ptr_q;
    logic [23:0]   stage_q;
    logic [31:0]   fifo_mem [FIFO_D];
    logic [AW:0]   wr_q, rd_q, fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          fetch_en_q, fetch_out_q, ovf_q, tmo_q;
    logic          busy, req, pop, flush;
    logic          wr_ptr, wr_stage, wr_push, wr_ctrl, clr_flags, push_ok, push_drop;
    logic [7:0]    rdata;

    assign fifo_cnt   = wr_q - rd_q;
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign req        = (state_q == S_REQ);

    // Pointer bytes are frozen while a load is in flight so the running address cannot be torn.
    assign wr_ptr    = io.reg_wr_i && (io.reg_addr_i < 4'd4) && !busy;
    assign wr_stage  = io.reg_wr_i && (io.reg_addr_i >= 4'd4) && (io.reg_addr_i <= 4'd6);
    assign wr_push   = io.reg_wr_i && (io.reg_addr_i == 4'd7);
    assign wr_ctrl   = io.reg_wr_i && (io.reg_addr_i == 4'd8);
    assign clr_flags = wr_ctrl && io.reg_wdata_i[1];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands then.
    assign push_ok   = wr_push && (!fifo_full || pop) && !flush;
    assign push_drop = wr_push && fifo_full && !pop;

    // FSM state and grant-wait counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state: IDLE also reacts to a push in flight so the request starts one cycle after DATA3.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (!fifo_empty || wr_push) state_d = S_REQ;
            end
            S_REQ: begin
                if (io.bus_gnt_i) begin
                    pop     = 1'b1;
                    wait_d  = '0;
                    state_d = S_RESP;
                end else if (wait_q == WAIT_MAX) begin
                    flush   = 1'b1;
                    wait_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RESP: begin
                if (io.bus_rvalid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word pointer: advances on each granted word, wraps naturally at 2^32, host-writable when idle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (pop) begin
            ptr_q <= ptr_q + 32'd4;
        end else if (wr_ptr) begin
            ptr_q[{io.reg_addr_i[1:0], 3'b000} +: 8] <= io.reg_wdata_i;
        end
    end

    // Staging bytes DATA0..DATA2 hold their value across pushes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else if (wr_stage) begin
            stage_q[{io.reg_addr_i[1:0], 3'b000} +: 8] <= io.reg_wdata_i;
        end
    end

    // FIFO pointers; a timeout discards everything queued
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
        end
    end

    // FIFO storage; contents are only observed while requesting, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_q[AW-1:0]] <= {io.reg_wdata_i, stage_q};
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            if (clr_flags) begin
                ovf_q <= 1'b0;
                tmo_q <= 1'b0;
            end
            if (push_drop) ovf_q <= 1'b1;
            if (flush)     tmo_q <= 1'b1;
        end
    end

    // Fetch enable: host request gated by idleness, registered so it drops a cycle after loading resumes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_en_q  <= 1'b0;
            fetch_out_q <= 1'b0;
        end else begin
            if (wr_ctrl) fetch_en_q <= io.reg_wdata_i[0];
            fetch_out_q <= fetch_en_q && !busy;
        end
    end

    // Register readback, combinational on the address
    always_comb begin
        rdata = '0;
        case (io.reg_addr_i)
            4'd0, 4'd1, 4'd2, 4'd3: rdata = ptr_q[{io.reg_addr_i[1:0], 3'b000} +: 8];
            4'd4, 4'd5, 4'd6:       rdata = stage_q[{io.reg_addr_i[1:0], 3'b000} +: 8];
            4'd8:                   rdata = {7'd0, fetch_en_q};
            4'd9:                   rdata = {4'd0, tmo_q, ovf_q, fifo_full, busy};
            default:                rdata = '0;
        endcase
    end

    assign io.reg_rdata_o    = rdata;
    assign io.bus_req_o      = req;
    assign io.bus_we_o       = req;
    assign io.bus_be_o       = {4{req}};
    assign io.bus_addr_o     = req ? ptr_q : 32'd0;
    assign io.bus_wdata_o    = req ? fifo_mem[rd_q[AW-1:0]] : 32'd0;
    assign io.fetch_enable_o = fetch_out_q;
    assign io.busy_o         = busy;
    assign io.err_o          = ovf_q || tmo_q;
endmodule

// File: tb/tb_usb_mem_loader_ctrl.sv
// Bench for usb_mem_loader_ctrl: scenario tasks against an OBI responder and a word-level load model.
// Latency: checks one-cycle request start, grant stalls, timeout length and fetch-enable timing.
// Backpressure: grant delays and rvalid delays come from the responder, fixed or randomized.
module tb_usb_mem_loader_ctrl;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    usb_mem_loader_ctrl_if bus_if();

    usb_mem_loader_ctrl #(.TIMEOUT(TMO), .FIFO_D(2)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (bus_if.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // responder controls and observations
    bit gnt_never = 1'b0, gnt_rand = 1'b0, rv_rand = 1'b0;
    int gnt_wait = 0, rv_delay = 0;
    int last_req_len = 0, stab_err = 0, proto_err = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    // OBI memory model: grants after gnt_wait cycles, answers rvalid after a delay, logs accepted words
    initial begin : responder
        int wcnt, rcnt, rlen;
        bit rpend, req_prev;
        logic [31:0] a_prev, d_prev;
        wcnt = 0; rcnt = 0; rlen = 0; rpend = 0; req_prev = 0; a_prev = '0; d_prev = '0;
        bus_if.bus_gnt_i = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wcnt = 0; rpend = 0; req_prev = 0; rlen = 0;
                bus_if.bus_gnt_i = 1'b0;
                bus_if.bus_rvalid_i = 1'b0;
                continue;
            end
            if (bus_if.bus_gnt_i && req_prev) begin
                obs_addr.push_back(a_prev);
                obs_data.push_back(d_prev);
                rpend = 1'b1;
                rcnt = rv_rand ? int'($urandom_range(0, 3)) : rv_delay;
            end
            if (req_prev && !bus_if.bus_gnt_i && bus_if.bus_req_o &&
                (bus_if.bus_addr_o !== a_prev || bus_if.bus_wdata_o !== d_prev)) stab_err++;
            if (bus_if.bus_req_o) begin
                if (bus_if.bus_we_o !== 1'b1 || bus_if.bus_be_o !== 4'hF || bus_if.bus_addr_o[1:0] !== 2'b00)
                    proto_err++;
                rlen++;
            end else begin
                if (bus_if.bus_be_o !== 4'h0) proto_err++;
                if (rlen != 0) last_req_len = rlen;
                rlen = 0;
            end
            bus_if.bus_rvalid_i = 1'b0;
            if (rpend) begin
                if (rcnt == 0) begin
                    bus_if.bus_rvalid_i = 1'b1;
                    rpend = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            bus_if.bus_gnt_i = 1'b0;
            if (bus_if.bus_req_o && !gnt_never) begin
                if (wcnt >= gnt_wait) begin
                    bus_if.bus_gnt_i = 1'b1;
                    wcnt = 0;
                    if (gnt_rand) gnt_wait = int'($urandom_range(0, 4));
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            req_prev = bus_if.bus_req_o;
            a_prev = bus_if.bus_addr_o;
            d_prev = bus_if.bus_wdata_o;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        bus_if.reg_wr_i = 1'b1;
        bus_if.reg_addr_i = a;
        bus_if.reg_wdata_i = d;
        @(posedge clk); #1;
        bus_if.reg_wr_i = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        bus_if.reg_addr_i = a;
        #1;
        d = bus_if.reg_rdata_o;
    endtask

    task automatic write_ptr(input logic [31:0] p);
        for (int i = 0; i < 4; i++) reg_write(4'(i), p[8*i +: 8]);
    endtask

    task automatic read_ptr(output logic [31:0] p);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            reg_read(4'(i), b);
            p[8*i +: 8] = b;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus_if.busy_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic [31:0] p;
        rst_n = 1'b0;
        bus_if.reg_wr_i = 1'b0; bus_if.reg_addr_i = '0; bus_if.reg_wdata_i = '0;
        repeat (3) step();
        rst_n = 1'b1;
        n_vec++; if (bus_if.bus_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus_if.bus_req_o); end
        n_vec++; if (bus_if.bus_be_o !== 4'h0 || bus_if.bus_we_o !== 1'b0) begin n_err++; $display("FAIL reset_be_we: got %h/%b want 0/0", bus_if.bus_be_o, bus_if.bus_we_o); end
        n_vec++; if (bus_if.bus_addr_o !== 32'h0 || bus_if.bus_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus_if.bus_addr_o, bus_if.bus_wdata_o); end
        n_vec++; if ({bus_if.fetch_enable_o, bus_if.busy_o, bus_if.err_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus_if.fetch_enable_o, bus_if.busy_o, bus_if.err_o}); end
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", s); end
        read_ptr(p);
        n_vec++; if (p !== 32'h0) begin n_err++; $display("FAIL reset_ptr: got %h want 0", p); end
    endtask

    task automatic test_basic();
        logic [7:0] s;
        logic [31:0] p;
        int n0;
        bit ok;
        gnt_never = 0; gnt_rand = 0; gnt_wait = 0; rv_rand = 0; rv_delay = 1;
        write_ptr(32'h0000_1000);
        reg_write(4'd4, 8'h11); reg_write(4'd5, 8'h22); reg_write(4'd6, 8'h33);
        n0 = obs_addr.size();
        reg_write(4'd7, 8'h44);
        n_vec++; if (bus_if.bus_req_o !== 1'b1) begin n_err++; $display("FAIL basic_req_rise: got %b want 1", bus_if.bus_req_o); end
        n_vec++; if (bus_if.bus_addr_o !== 32'h1000) begin n_err++; $display("FAIL basic_addr: got %h want 00001000", bus_if.bus_addr_o); end
        n_vec++; if (bus_if.bus_wdata_o !== 32'h44332211) begin n_err++; $display("FAIL basic_wdata: got %h want 44332211", bus_if.bus_wdata_o); end
        reg_read(4'd4, s);
        n_vec++; if (s !== 8'h11) begin n_err++; $display("FAIL basic_stage_rd: got %h want 11", s); end
        reg_read(4'hF, s);
        n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL basic_unmapped_rd: got %h want 00", s); end
        wait_idle(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (obs_addr.size() != n0 + 1) begin n_err++; $display("FAIL basic_count: got %0d want %0d", obs_addr.size() - n0, 1); end
        else if (obs_addr[n0] !== 32'h1000 || obs_data[n0] !== 32'h44332211) begin n_err++; $display("FAIL basic_txn: got %h/%h want 00001000/44332211", obs_addr[n0], obs_data[n0]); end
        read_ptr(p);
        n_vec++; if (p !== 32'h1004) begin n_err++; $display("FAIL basic_ptr: got %h want 00001004", p); end
    endtask

    task automatic test_stall();
        logic [31:0] p0, p, w;
        int n0, s0;
        bit ok;
        gnt_wait = 5; gnt_rand = 0;
        read_ptr(p0);
        w = $urandom();
        reg_write(4'd4, w[7:0]); reg_write(4'd5, w[15:8]); reg_write(4'd6, w[23:16]);
        n0 = obs_addr.size(); s0 = stab_err;
        reg_write(4'd7, w[31:24]);
        reg_write(4'd0, 8'hA5);
        wait_idle(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (last_req_len != 6) begin n_err++; $display("FAIL stall_req_len: got %0d want 6", last_req_len); end
        n_vec++; if (stab_err != s0) begin n_err++; $display("FAIL stall_stable: got %0d changes want 0", stab_err - s0); end
        n_vec++; if (obs_addr.size() != n0 + 1) begin n_err++; $display("FAIL stall_pops: got %0d want 1", obs_addr.size() - n0); end
        else if (obs_addr[n0] !== p0 || obs_data[n0] !== w) begin n_err++; $display("FAIL stall_txn: got %h/%h want %h/%h", obs_addr[n0], obs_data[n0], p0, w); end
        read_ptr(p);
        n_vec++; if (p !== p0 + 32'd4) begin n_err++; $display("FAIL stall_ptr_locked: got %h want %h", p, p0 + 32'd4); end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic [31:0] p0, p;
        int n0;
        bit ok;
        gnt_never = 1; gnt_wait = 0;
        read_ptr(p0);
        reg_write(4'd4, 8'h01); reg_write(4'd5, 8'h02); reg_write(4'd6, 8'h03);
        n0 = obs_addr.size();
        reg_write(4'd7, 8'hA1); reg_write(4'd7, 8'hA2); reg_write(4'd7, 8'hA3);
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h07) begin n_err++; $display("FAIL ovf_status: got %h want 07", s); end
        n_vec++; if (bus_if.err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %b want 1", bus_if.err_o); end
        reg_write(4'd8, 8'h02);
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h03) begin n_err++; $display("FAIL ovf_clear_status: got %h want 03", s); end
        n_vec++; if (bus_if.err_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear_err: got %b want 0", bus_if.err_o); end
        gnt_never = 0;
        wait_idle(60, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (obs_addr.size() != n0 + 2) begin n_err++; $display("FAIL ovf_queued: got %0d want 2", obs_addr.size() - n0); end
        else if (obs_data[n0] !== 32'hA1030201 || obs_data[n0+1] !== 32'hA2030201 ||
                 obs_addr[n0] !== p0 || obs_addr[n0+1] !== p0 + 32'd4) begin
            n_err++; $display("FAIL ovf_words: got %h@%h %h@%h want A1030201@%h A2030201@%h",
                              obs_data[n0], obs_addr[n0], obs_data[n0+1], obs_addr[n0+1], p0, p0 + 32'd4);
        end
        read_ptr(p);
        n_vec++; if (p !== p0 + 32'd8) begin n_err++; $display("FAIL ovf_ptr: got %h want %h", p, p0 + 32'd8); end
    endtask

    task automatic test_timeout();
        logic [7:0] s;
        logic [31:0] p0, p;
        int n0;
        gnt_never = 1;
        read_ptr(p0);
        n0 = obs_addr.size();
        reg_write(4'd7, 8'h5A);
        repeat (TMO - 1) step();
        reg_write(4'd8, 8'h02);
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h08) begin n_err++; $display("FAIL tmo_status_err_wins: got %h want 08", s); end
        n_vec++; if (bus_if.bus_req_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin n_err++; $display("FAIL tmo_req_drop: req=%b busy=%b want 0/0", bus_if.bus_req_o, bus_if.busy_o); end
        n_vec++; if (last_req_len != TMO) begin n_err++; $display("FAIL tmo_req_len: got %0d want %0d", last_req_len, TMO); end
        n_vec++; if (bus_if.err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", bus_if.err_o); end
        n_vec++; if (obs_addr.size() != n0) begin n_err++; $display("FAIL tmo_no_txn: got %0d want 0", obs_addr.size() - n0); end
        read_ptr(p);
        n_vec++; if (p !== p0) begin n_err++; $display("FAIL tmo_ptr: got %h want %h", p, p0); end
        reg_write(4'd8, 8'h02);
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL tmo_clear: got %h want 00", s); end
        gnt_never = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] w0, w1, p;
        int n0;
        bit ok;
        gnt_rand = 1; rv_rand = 1;
        write_ptr(32'hFFFF_FFFC);
        w0 = $urandom(); w1 = $urandom();
        n0 = obs_addr.size();
        reg_write(4'd4, w0[7:0]); reg_write(4'd5, w0[15:8]); reg_write(4'd6, w0[23:16]); reg_write(4'd7, w0[31:24]);
        reg_write(4'd4, w1[7:0]); reg_write(4'd5, w1[15:8]); reg_write(4'd6, w1[23:16]); reg_write(4'd7, w1[31:24]);
        wait_idle(80, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (obs_addr.size() != n0 + 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", obs_addr.size() - n0); end
        else if (obs_addr[n0] !== 32'hFFFF_FFFC || obs_addr[n0+1] !== 32'h0 || obs_data[n0] !== w0 || obs_data[n0+1] !== w1) begin
            n_err++; $display("FAIL wrap_txn: got %h@%h %h@%h want %h@fffffffc %h@00000000",
                              obs_data[n0], obs_addr[n0], obs_data[n0+1], obs_addr[n0+1], w0, w1);
        end
        read_ptr(p);
        n_vec++; if (p !== 32'h4) begin n_err++; $display("FAIL wrap_ptr: got %h want 00000004", p); end
    endtask

    task automatic test_fetch();
        int bad;
        bit ok;
        gnt_rand = 0; gnt_wait = 3; rv_rand = 0; rv_delay = 2;
        reg_write(4'd7, 8'hC3);
        reg_write(4'd8, 8'h01);
        bad = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus_if.busy_o) begin ok = 1; break; end
            if (bus_if.fetch_enable_o) bad++;
            step();
        end
        n_vec++; if (!ok) begin n_err++; $display("FAIL fetch_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL fetch_while_busy: got %0d high cycles want 0", bad); end
        n_vec++; if (bus_if.fetch_enable_o !== 1'b0) begin n_err++; $display("FAIL fetch_first_idle: got %b want 0", bus_if.fetch_enable_o); end
        step();
        n_vec++; if (bus_if.fetch_enable_o !== 1'b1) begin n_err++; $display("FAIL fetch_rise: got %b want 1", bus_if.fetch_enable_o); end
        reg_write(4'd7, 8'h3C);
        n_vec++; if (bus_if.fetch_enable_o !== 1'b1) begin n_err++; $display("FAIL fetch_hold: got %b want 1", bus_if.fetch_enable_o); end
        step();
        n_vec++; if (bus_if.fetch_enable_o !== 1'b0) begin n_err++; $display("FAIL fetch_drop_on_load: got %b want 0", bus_if.fetch_enable_o); end
        wait_idle(60, ok);
        step();
        n_vec++; if (bus_if.fetch_enable_o !== 1'b1) begin n_err++; $display("FAIL fetch_rerise: got %b want 1", bus_if.fetch_enable_o); end
        reg_write(4'd8, 8'h00);
        step();
        n_vec++; if (bus_if.fetch_enable_o !== 1'b0) begin n_err++; $display("FAIL fetch_off: got %b want 0", bus_if.fetch_enable_o); end
    endtask

    task automatic test_random();
        logic [31:0] ptr_m, p;
        logic [7:0] st [3];
        logic [7:0] s, b, d3;
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        int n0, s0, e0;
        bit ok;
        gnt_never = 0; gnt_rand = 1; rv_rand = 1;
        ptr_m = $urandom() & 32'hFFFF_FFFC;
        write_ptr(ptr_m);
        for (int j = 0; j < 3; j++) begin
            st[j] = 8'($urandom());
            reg_write(4'(4 + j), st[j]);
        end
        n0 = obs_addr.size(); s0 = stab_err; e0 = proto_err;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    b = 8'($urandom());
                    reg_write(4'(4 + j), b);
                    st[j] = b;
                end
            end
            for (int i = 0; i < 100; i++) begin
                reg_read(4'd9, s);
                if (!s[1]) break;
                step();
            end
            d3 = 8'($urandom());
            reg_write(4'd7, d3);
            exp_a.push_back(ptr_m);
            exp_d.push_back({d3, st[2], st[1], st[0]});
            ptr_m = ptr_m + 32'd4;
        end
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rand_idle_timeout: busy=%b want 0", bus_if.busy_o); end
        n_vec++; if (obs_addr.size() - n0 != exp_a.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", obs_addr.size() - n0, exp_a.size()); end
        for (int i = 0; i < exp_a.size() && n0 + i < obs_addr.size(); i++) begin
            n_vec++;
            if (obs_addr[n0+i] !== exp_a[i] || obs_data[n0+i] !== exp_d[i]) begin
                n_err++; $display("FAIL rand_txn[%0d]: got %h@%h want %h@%h", i, obs_data[n0+i], obs_addr[n0+i], exp_d[i], exp_a[i]);
            end
        end
        read_ptr(p);
        n_vec++; if (p !== ptr_m) begin n_err++; $display("FAIL rand_ptr: got %h want %h", p, ptr_m); end
        n_vec++; if (bus_if.err_o !== 1'b0) begin n_err++; $display("FAIL rand_err: got %b want 0", bus_if.err_o); end
        n_vec++; if (proto_err != e0 || stab_err != s0) begin n_err++; $display("FAIL rand_protocol: got %0d/%0d violations want 0/0", proto_err - e0, stab_err - s0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic [31:0] p;
        int n0;
        bit ok;
        gnt_never = 1; gnt_rand = 0; gnt_wait = 0; rv_rand = 0; rv_delay = 0;
        write_ptr(32'h0000_2000);
        reg_write(4'd7, 8'h01); reg_write(4'd7, 8'h02); reg_write(4'd7, 8'h03);
        n_vec++; if (bus_if.bus_req_o !== 1'b1 || bus_if.err_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: req=%b err=%b want 1/1", bus_if.bus_req_o, bus_if.err_o); end
        rst_n = 1'b0;
        step();
        n_vec++; if (bus_if.bus_req_o !== 1'b0 || bus_if.busy_o !== 1'b0 || bus_if.err_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: req=%b busy=%b err=%b want 0/0/0", bus_if.bus_req_o, bus_if.busy_o, bus_if.err_o);
        end
        reg_read(4'd9, s);
        n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL rstmid_status: got %h want 00", s); end
        read_ptr(p);
        n_vec++; if (p !== 32'h0) begin n_err++; $display("FAIL rstmid_ptr: got %h want 0", p); end
        rst_n = 1'b1;
        gnt_never = 0;
        step();
        n0 = obs_addr.size();
        reg_write(4'd4, 8'hEF); reg_write(4'd5, 8'hBE); reg_write(4'd6, 8'hAD); reg_write(4'd7, 8'hDE);
        wait_idle(50, ok);
        repeat (4) step();
        n_vec++; if (obs_addr.size() != n0 + 1) begin n_err++; $display("FAIL rstmid_flushed: got %0d words want 1", obs_addr.size() - n0); end
        else if (obs_addr[n0] !== 32'h0 || obs_data[n0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rstmid_txn: got %h@%h want deadbeef@00000000", obs_data[n0], obs_addr[n0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_timeout();
        test_wrap();
        test_fetch();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule
